// File: rtl/food_spawner.sv
// Food slot manager for the snake game: detects the head eating a food cell on each
// game tick and respawns that slot at an LFSR-chosen free cell checked against the body.
module food_spawner #(
  parameter int          GRID_W    = 40,
  parameter int          GRID_H    = 30,
  parameter int          X_W       = 6,
  parameter int          Y_W       = 5,
  parameter int          BORDER    = 1,
  parameter int          NUM_FOOD  = 2,
  parameter int          TICK_DIV  = 250000,
  parameter int          MAX_TRIES = 16,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [X_W-1:0]          headx,
  input  logic [Y_W-1:0]          heady,
  output logic                    occ_req,
  output logic [X_W-1:0]          occ_x,
  output logic [Y_W-1:0]          occ_y,
  input  logic                    occ_ack,
  input  logic                    occ_hit,
  output logic [NUM_FOOD*X_W-1:0] foodx,
  output logic [NUM_FOOD*Y_W-1:0] foody,
  output logic [NUM_FOOD-1:0]     food_valid,
  output logic                    add,
  output logic [2:0]              eat_slot,
  output logic [15:0]             score,
  output logic                    busy,
  output logic                    spawn_fail
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {IDLE, GEN, QUERY, WAIT, PLACE} state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [CNT_W-1:0] cnt;
  logic [TRY_W-1:0] tries;
  logic [TRY_W-1:0] tries_inc;
  logic [2:0]       target;
  logic             tick;
  logic [X_W-1:0]   cx;
  logic [Y_W-1:0]   cy;
  logic             eat_hit;
  logic             any_free;
  logic             cand_ok;
  logic [2:0]       eat_idx;
  logic [2:0]       free_idx;
  logic [15:0]      score_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= SEED;
    else      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  assign tick      = (cnt == CNT_W'(TICK_DIV - 1));
  assign cx        = lfsr[X_W-1:0];
  assign cy        = lfsr[X_W+Y_W-1:X_W];
  assign tries_inc = tries + TRY_W'(1);

  // NOTE: every output of a combinational block gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    eat_hit  = 1'b0;
    eat_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    cand_ok  = (int'(cx) >= BORDER) && (int'(cx) <= GRID_W - 1 - BORDER) &&
               (int'(cy) >= BORDER) && (int'(cy) <= GRID_H - 1 - BORDER) &&
               !(cx == headx && cy == heady);
    // Descending scan so the lowest matching index wins.
    for (int i = NUM_FOOD - 1; i >= 0; i--) begin
      if (food_valid[i] && foodx[i*X_W +: X_W] == headx && foody[i*Y_W +: Y_W] == heady) begin
        eat_hit = 1'b1;
        eat_idx = 3'(i);
      end
      if (!food_valid[i]) begin
        any_free = 1'b1;
        free_idx = 3'(i);
      end
      if (food_valid[i] && foodx[i*X_W +: X_W] == cx && foody[i*Y_W +: Y_W] == cy)
        cand_ok = 1'b0;
    end
  end

  always_comb begin
    score_nxt = score;
    if (state == IDLE && tick && eat_hit && score != 16'hFFFF)
      score_nxt = score + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tries      <= '0;
      target     <= '0;
      occ_req    <= 1'b0;
      occ_x      <= '0;
      occ_y      <= '0;
      foodx      <= '0;
      foody      <= '0;
      food_valid <= '0;
      add        <= 1'b0;
      eat_slot   <= '0;
      score      <= '0;
      busy       <= 1'b0;
      spawn_fail <= 1'b0;
    end else begin
      add        <= 1'b0;
      spawn_fail <= 1'b0;
      occ_req    <= 1'b0;
      score      <= score_nxt;
      case (state)
        IDLE: begin
          if (tick && eat_hit) begin
            for (int i = 0; i < NUM_FOOD; i++)
              if (i == int'(eat_idx)) food_valid[i] <= 1'b0;
            add      <= 1'b1;
            eat_slot <= eat_idx;
            target   <= eat_idx;
            tries    <= '0;
            busy     <= 1'b1;
            state    <= GEN;
          end else if (tick && any_free) begin
            target <= free_idx;
            tries  <= '0;
            busy   <= 1'b1;
            state  <= GEN;
          end
        end
        GEN: begin
          tries <= tries_inc;
          if (cand_ok) begin
            occ_req <= 1'b1;
            occ_x   <= cx;
            occ_y   <= cy;
            state   <= QUERY;
          end else if (tries_inc >= TRY_W'(MAX_TRIES)) begin
            spawn_fail <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        QUERY: state <= WAIT;
        WAIT: begin
          if (occ_ack) begin
            if (!occ_hit) begin
              state <= PLACE;
            end else if (tries >= TRY_W'(MAX_TRIES)) begin
              spawn_fail <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              state <= GEN;
            end
          end
        end
        PLACE: begin
          for (int i = 0; i < NUM_FOOD; i++) begin
            if (i == int'(target)) begin
              foodx[i*X_W +: X_W] <= occ_x;
              foody[i*Y_W +: Y_W] <= occ_y;
              food_valid[i]       <= 1'b1;
            end
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_food_spawner.sv
// Self-checking bench for food_spawner: directed scenarios plus randomized ticks,
// checked against a spec-level model of the candidate sequence and spawn timing.
module tb_food_spawner;

  localparam int X_W       = 6;
  localparam int Y_W       = 5;
  localparam int NF        = 2;
  localparam int TICK_DIV  = 8;
  localparam int MAX_TRIES = 8;
  localparam int LF_N      = 8192;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [X_W-1:0]    headx;
  logic [Y_W-1:0]    heady;
  logic              occ_req;
  logic [X_W-1:0]    occ_x;
  logic [Y_W-1:0]    occ_y;
  logic              occ_ack;
  logic              occ_hit;
  logic [NF*X_W-1:0] foodx;
  logic [NF*Y_W-1:0] foody;
  logic [NF-1:0]     food_valid;
  logic              add;
  logic [2:0]        eat_slot;
  logic [15:0]       score;
  logic              busy;
  logic              spawn_fail;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int cyc = 0;
  int hx = 0, hy = 0;
  int stub_lat = 1, hit_until = 0, q_total = 0, rem = 0;
  bit cur_hit = 1'b0;
  logic [15:0] lf [0:LF_N-1];
  bit mv [0:NF-1];
  int mx [0:NF-1];
  int my [0:NF-1];
  int mscore = 0;

  assign headx = hx[X_W-1:0];
  assign heady = hy[Y_W-1:0];

  always #5 clk = ~clk;

  food_spawner #(
    .GRID_W(40), .GRID_H(30), .X_W(X_W), .Y_W(Y_W), .BORDER(1), .NUM_FOOD(NF),
    .TICK_DIV(TICK_DIV), .MAX_TRIES(MAX_TRIES), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .headx(headx), .heady(heady),
    .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit),
    .foodx(foodx), .foody(foody), .food_valid(food_valid), .add(add),
    .eat_slot(eat_slot), .score(score), .busy(busy), .spawn_fail(spawn_fail)
  );

  // Cycle index since reset release; during cycle k the LFSR holds SEED stepped k times.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Snake-body stub: acks stub_lat cycles after occ_req (0 = never); queries numbered
  // below hit_until report body.
  always @(posedge clk) begin
    if (!rst) begin
      occ_ack <= 1'b0;
      occ_hit <= 1'b0;
      rem     <= 0;
    end else begin
      occ_ack <= 1'b0;
      occ_hit <= 1'b0;
      if (occ_req) begin
        q_total <= q_total + 1;
        cur_hit <= (q_total < hit_until);
        if (stub_lat == 1) begin
          occ_ack <= 1'b1;
          occ_hit <= (q_total < hit_until);
        end else if (stub_lat > 1) begin
          rem <= stub_lat - 1;
        end
      end else if (rem != 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          occ_ack <= 1'b1;
          occ_hit <= cur_hit;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed cyc=%0d required <%0d", cyc, LF_N);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  function automatic bit legal(input int x, input int y);
    return x >= 1 && x <= 38 && y >= 1 && y <= 28;
  endfunction

  // Replays the spawn rules over the LFSR sequence: one candidate per GEN cycle,
  // QUERY takes one cycle, WAIT lasts lat cycles, PLACE one more.
  task automatic predict(input int t, input int lat, input int hits, output bit fail,
                         output int done, output int px, output int py, output int nq);
    int c, cx, cy;
    bit ok, fin;
    c = t + 1; nq = 0; fail = 0; done = 0; px = 0; py = 0; fin = 0;
    for (int g = 0; g < MAX_TRIES && !fin; g++) begin
      cx = int'(lf[c]) % 64;
      cy = (int'(lf[c]) / 64) % 32;
      ok = legal(cx, cy) && !(cx == hx && cy == hy);
      for (int i = 0; i < NF; i++)
        if (mv[i] && cx == mx[i] && cy == my[i]) ok = 0;
      if (!ok) begin
        if (g + 1 == MAX_TRIES) begin fail = 1; done = c + 1; fin = 1; end
        else c = c + 1;
      end else begin
        nq++;
        if (nq <= hits) begin
          if (g + 1 == MAX_TRIES) begin fail = 1; done = c + 2 + lat; fin = 1; end
          else c = c + 2 + lat;
        end else begin
          px = cx; py = cy; done = c + 3 + lat; fin = 1;
        end
      end
    end
  endtask

  task automatic run_tick(input int lat, input int hits);
    int t, s, q0, done, px, py, nq;
    bit eat, fail;
    t = cyc + (7 - cyc % TICK_DIV);
    s = -1; eat = 0;
    for (int i = 0; i < NF; i++)
      if (s < 0 && mv[i] && mx[i] == hx && my[i] == hy) begin s = i; eat = 1; end
    for (int i = 0; i < NF; i++)
      if (s < 0 && !mv[i]) s = i;
    stub_lat = lat; hit_until = q_total + hits; q0 = q_total;
    if (eat) begin
      mv[s] = 0;
      if (mscore < 'hFFFF) mscore++;
    end
    wait_cyc(t + 1);
    check("add", int'(add), int'(eat));
    check("score", int'(score), mscore);
    if (eat) begin
      check("eat_slot", int'(eat_slot), s);
      check("eaten_invalid", int'(food_valid[s]), 0);
    end
    if (s < 0) return;
    predict(t, lat, hits, fail, done, px, py, nq);
    wait_cyc(t + 2);
    check("add_one_cycle", int'(add), 0);
    wait_cyc(done - 1);
    check("busy_during_spawn", int'(busy), 1);
    check("not_valid_early", int'(food_valid[s]), 0);
    wait_cyc(done);
    check("spawn_fail", int'(spawn_fail), int'(fail));
    check("slot_valid", int'(food_valid[s]), int'(!fail));
    check("busy_after", int'(busy), 0);
    check("query_count", q_total - q0, nq);
    if (!fail) begin
      check("foodx", int'(foodx[s*X_W +: X_W]), px);
      check("foody", int'(foody[s*Y_W +: Y_W]), py);
      mv[s] = 1; mx[s] = px; my[s] = py;
    end else if (done % TICK_DIV != 7) begin
      wait_cyc(done + 1);
      check("fail_single_pulse", int'(spawn_fail), 0);
    end
  endtask

  task automatic check_reset_values();
    check("rst_occ_req", int'(occ_req), 0);
    check("rst_occ_xy", int'({occ_x, occ_y}), 0);
    check("rst_food_xy", int'({foodx, foody}), 0);
    check("rst_food_valid", int'(food_valid), 0);
    check("rst_add", int'(add), 0);
    check("rst_eat_slot", int'(eat_slot), 0);
    check("rst_score", int'(score), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_spawn_fail", int'(spawn_fail), 0);
  endtask

  task automatic aim_head();
    int s;
    s = -1;
    for (int i = 0; i < NF; i++) if (s < 0 && mv[i]) s = i;
    if (s >= 0) begin hx = mx[s]; hy = my[s]; end
    else begin hx = 0; hy = 0; end
  endtask

  initial begin
    int t, done, px, py, nq, q0, eats, s;
    bit fail;
    lf[0] = 16'hACE1;
    for (int k = 1; k < LF_N; k++) begin
      lf[k] = lf[k-1] >> 1;
      if (lf[k-1][0]) lf[k] = lf[k] ^ 16'hB400;
    end
    for (int i = 0; i < NF; i++) begin mv[i] = 0; mx[i] = 0; my[i] = 0; end

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b1;

    // Fill both slots, head parked on the wall
    hx = 0; hy = 0;
    run_tick(1, 0);
    check("fill_first", int'(food_valid), int'({mv[1], mv[0]}));
    run_tick(1, 0);
    check("fill_both", int'(food_valid), int'({mv[1], mv[0]}));
    check("slot0_legal", int'(legal(int'(foodx[5:0]), int'(foody[4:0]))), int'(mv[0]));
    check("slot1_legal", int'(legal(int'(foodx[11:6]), int'(foody[9:5]))), int'(mv[1]));
    check("slots_distinct", int'(mv[0] && mv[1] && {foodx[5:0], foody[4:0]} == {foodx[11:6], foody[9:5]}), 0);

    // Eat slot 1
    if (mv[1]) begin hx = mx[1]; hy = my[1]; end
    run_tick(1, 0);

    // Body hit on the first three queries
    aim_head();
    run_tick(1, 3);

    // Body everywhere: spawn gives up, then the slot is retried on the next tick
    aim_head();
    run_tick(1, 1000);
    run_tick(1, 0);

    // Randomized heads, ack latencies and body hits
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 1) == 1) aim_head();
      else begin hx = $urandom_range(0, 39); hy = $urandom_range(0, 29); end
      run_tick($urandom_range(1, 3), $urandom_range(0, 2));
    end

    // Reset while waiting for an ack that never comes
    aim_head();
    t = cyc + (7 - cyc % TICK_DIV);
    predict(t, 1000, 0, fail, done, px, py, nq);
    stub_lat = 0; q0 = q_total;
    wait_cyc(t + 1);
    for (int k = 0; k < 40 && q_total == q0; k++) @(negedge clk);
    check("query_before_reset", int'(q_total != q0), int'(!fail));
    repeat (2) @(negedge clk);
    check("busy_in_wait", int'(busy), int'(!fail));
    rst = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b1;
    stub_lat = 1;
    for (int i = 0; i < NF; i++) mv[i] = 0;
    mscore = 0; hx = 0; hy = 0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", int'(busy), 0);
    check("empty_after_reset", int'(food_valid), 0);

    // Refill, preload score near the top, then eat three times
    for (int k = 0; k < 6 && !(mv[0] && mv[1]); k++) run_tick(1, 0);
    force dut.score = 16'hFFFE;
    @(negedge clk);
    release dut.score;
    mscore = 'hFFFE;
    check("score_preload", int'(score), 'hFFFE);
    eats = 0;
    for (int k = 0; k < 12 && eats < 3; k++) begin
      s = -1;
      for (int i = 0; i < NF; i++) if (s < 0 && mv[i]) s = i;
      if (s >= 0) begin hx = mx[s]; hy = my[s]; eats++; end
      else begin hx = 0; hy = 0; end
      run_tick(1, 0);
    end
    check("saturating_eats", eats, 3);
    check("score_saturated", int'(score), 'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
